// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: merges ALU results and FIFO-buffered load results onto the
// register-file write port and tracks pending destinations. WB_FWD_EN adds a bypass port.
module regfile_wb_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic [31:0]       pending,
  output logic              wrt_en,
  output logic [4:0]        wrt_addr,
  output logic [DATA_W-1:0] dataD
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [4:0]        fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              full, empty, push, pop;
  logic              sel_alu, sel_fifo, commit;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       pend_next;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_ready = !full;
  assign push      = mem_valid && mem_ready;

  // Empty test uses the registered count, so a fresh push cannot fall through.
  always_comb begin
    sel_fifo = full || (!alu_valid && !empty);
    sel_alu  = !full && alu_valid;
    pop      = sel_fifo;
    sel_rd   = sel_fifo ? fifo_rd[rd_ptr]   : alu_rd;
    sel_data = sel_fifo ? fifo_data[rd_ptr] : alu_data;
    commit   = (sel_alu || sel_fifo) && (sel_rd != '0);
  end

  // Clear for the write being registered happens first so a same-cycle issue wins.
  always_comb begin
    pend_next = pending;
    if (commit)
      pend_next[sel_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      pend_next[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      wrt_en   <= 1'b0;
      wrt_addr <= '0;
      dataD    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending <= pend_next;
      wrt_en  <= commit;
      if (commit) begin
        wrt_addr <= sel_rd;
        dataD    <= sel_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = commit;
  assign fwd_addr  = sel_rd;
  assign fwd_data  = sel_data;
`endif

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback controller that drives the single write port of the integer register file (wrt_en / wrt_addr / dataD).
- Merges two result sources: single-cycle ALU results and variable-latency load results. Load results are buffered in a small FIFO.
- Tracks which destination registers have results still pending, for the issue stage's hazard check.
- Sits between the EX/MEM result paths and the register file.

Parameters:
DEPTH, 4, load-result FIFO entries; power of two, >= 2
DATA_W, 32, result data width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_rd  in  5  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  FIFO can accept (combinational, = !full)
mem_rd  in  5  load destination register
mem_data  in  DATA_W  load result
iss_valid  in  1  instruction issued with a destination
iss_rd  in  5  issued destination register
pending  out  32  bit i = 1 while a write to xi is outstanding
wrt_en  out  1  register-file write enable (registered)
wrt_addr  out  5  register-file write address (registered)
dataD  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async assert, sync release): wrt_en=0, wrt_addr=0, dataD=0, FIFO empty (count=0, pointers 0), pending=0. Asserting reset mid-operation discards FIFO contents and all pending bits.
- Load FIFO:
  - Push when mem_valid && mem_ready.
  - mem_ready = (count != DEPTH). It is deasserted when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - count is DEPTH+1 states wide.
- Arbitration, evaluated each cycle:
  - If count == DEPTH, the FIFO head wins and alu_ready=0.
  - Otherwise alu_ready=1. If alu_valid, the ALU result is selected; else, if count != 0, the FIFO head is selected (pop).
  - At most one source is selected per cycle.
- Write output latency: the selected result appears on wrt_en / wrt_addr / dataD on the next rising edge, held for exactly one cycle.
  - With no selection, wrt_en=0 and wrt_addr/dataD hold their previous values.
- x0: a selected result with rd=0 completes its handshake or pop but produces wrt_en=0. x0 never sets a pending bit.
- Same-cycle FIFO push and pop (count not full, not empty): count unchanged; FIFO order preserved.
- Push into an empty FIFO: the entry is not eligible for pop until the next cycle (no fall-through).
- Scoreboard:
  - iss_valid && iss_rd != 0 sets pending[iss_rd] on the clock edge.
  - The edge on which wrt_en=1 is registered for address r clears pending[r].
  - Simultaneous set and clear of the same r: set wins.
- Consistency check: the bench flags any write to r while pending[r]=0 (when the check is enabled).

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (5), fwd_data (DATA_W). They present the result selected this cycle combinationally, one cycle before the register-file write, so EX can bypass. fwd_valid=0 for rd=0 or no selection.
- Undefined: these ports are absent; there is no bypass path.

Test Plan:
- Reset then ALU only: alu_valid=1, rd=5, data=0x1234 -> next edge wrt_en=1, wrt_addr=5, dataD=0x1234; pending[5] cleared if previously issued.
- ALU/load contention: one load (rd=7, 0xAA) queued, ALU streaming rd=3 for 3 cycles -> three writes to x3, then a write to x7 with 0xAA on the 4th write cycle.
- FIFO full: 4 loads pushed while the ALU streams -> mem_ready=0 at count=4; alu_ready=0 and the head drains first; FIFO order 0..3 preserved; no data loss.
- x0 discard: ALU rd=0, data=0xFFFF -> alu_ready=1, wrt_en stays 0, pending unchanged.
- Scoreboard race: pending[9]=1, write to x9 commits on the same edge as iss_valid with rd=9 -> pending[9] remains 1.
- Async reset mid-stream: reset_n low with 2 FIFO entries -> immediately wrt_en=0, pending=0, mem_ready=1; after release there are no stale writes.
